// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the load/store unit and the
// mips_cpu_bus datapath (which maps opcodes onto lsu_op_t).
//   lsu_op_t    : memory operation requested by the CPU
//   lsu_state_t : load/store unit sequencer states
//   lane constants and the is_store helper
// Optional feature macro: MIPS_LSU_UNALIGNED_EN (enables LWL/LWR/SWL/SWR).
package mips_pkg;

  localparam int unsigned LSU_DATA_W = 32;
  localparam int unsigned LSU_BYTE_W = 8;
  localparam int unsigned LSU_LANES  = LSU_DATA_W / LSU_BYTE_W;

  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LBU = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LHU = 4'd3,
    LSU_LW  = 4'd4,
    LSU_SB  = 4'd5,
    LSU_SH  = 4'd6,
    LSU_SW  = 4'd7,
    LSU_LWL = 4'd8,
    LSU_LWR = 4'd9,
    LSU_SWL = 4'd10,
    LSU_SWR = 4'd11
  } lsu_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_BUS   = 2'd1,
    LSU_RDATA = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic lsu_is_store(input lsu_op_t op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW) ||
           (op == LSU_SWL) || (op == LSU_SWR);
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: combinational byte-lane logic for the load/store unit.
// Request side (from the incoming request):
//   st_op, st_k, st_data -> st_be (lane enables), st_wdata (lane-steered
//   store data), st_err (misaligned access or op not enabled in this build)
// Load side (from the latched request and bus read data):
//   ld_op, ld_k, ld_rdata, ld_old -> ld_result (extracted, extended or
//   merged load value)
// Lanes are little-endian: lane k holds bits [8k+7:8k].
// Optional feature macro: MIPS_LSU_UNALIGNED_EN (LWL/LWR/SWL/SWR steering).
module mips_lsu_align
  import mips_pkg::*;
(
  input  lsu_op_t     st_op,
  input  logic [1:0]  st_k,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_err,
  input  lsu_op_t     ld_op,
  input  logic [1:0]  ld_k,
  input  logic [31:0] ld_rdata,
  input  logic [31:0] ld_old,
  output logic [31:0] ld_result
);

  logic [4:0]  ld_sh;
  logic [31:0] ld_shifted;

  assign ld_sh      = {ld_k, 3'b000};
  assign ld_shifted = ld_rdata >> ld_sh;

  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    st_err   = 1'b0;
    case (st_op)
      LSU_LB, LSU_LBU: st_be = 4'b0001 << st_k;
      LSU_SB: begin
        st_be    = 4'b0001 << st_k;
        st_wdata = {4{st_data[7:0]}};
      end
      LSU_LH, LSU_LHU: begin
        st_err = st_k[0];
        st_be  = st_k[1] ? 4'b1100 : 4'b0011;
      end
      LSU_SH: begin
        st_err   = st_k[0];
        st_be    = st_k[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      LSU_LW: begin
        st_err = |st_k;
        st_be  = 4'b1111;
      end
      LSU_SW: begin
        st_err   = |st_k;
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
`ifdef MIPS_LSU_UNALIGNED_EN
      // Left ops cover lanes 0..k, right ops cover lanes k..3.
      LSU_LWL: st_be = ~(4'b1110 << st_k);
      LSU_LWR: st_be = 4'b1111 << st_k;
      LSU_SWL: begin
        st_be    = ~(4'b1110 << st_k);
        st_wdata = st_data >> {~st_k, 3'b000};
      end
      LSU_SWR: begin
        st_be    = 4'b1111 << st_k;
        st_wdata = st_data << {st_k, 3'b000};
      end
`endif
      default: st_err = 1'b1;
    endcase
  end

`ifdef MIPS_LSU_UNALIGNED_EN
  logic [31:0] lwl_keep;
  logic [31:0] lwr_keep;
  // LWL keeps the low (3-k) bytes of rt, LWR keeps the high k bytes.
  assign lwl_keep = ~(32'hFFFF_FFFF << {~ld_k, 3'b000});
  assign lwr_keep = ~(32'hFFFF_FFFF >> ld_sh);
`else
  logic unused_ld_old;
  assign unused_ld_old = ^ld_old;
`endif

  always_comb begin
    ld_result = '0;
    case (ld_op)
      LSU_LB:  ld_result = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_LBU: ld_result = {24'd0, ld_shifted[7:0]};
      LSU_LH:  ld_result = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LSU_LHU: ld_result = {16'd0, ld_shifted[15:0]};
      LSU_LW:  ld_result = ld_rdata;
`ifdef MIPS_LSU_UNALIGNED_EN
      LSU_LWL: ld_result = (ld_rdata << {~ld_k, 3'b000}) | (ld_old & lwl_keep);
      LSU_LWR: ld_result = ld_shifted | (ld_old & lwr_keep);
`endif
      default: ld_result = '0;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit turning one CPU request into one Avalon-MM
// master transaction (byte/half/word loads and stores).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op/addr/wdata     operation, byte address, store data / old rt
//   resp_valid/rdata/err  one-cycle completion pulse with result and error
//   address/read/write    Avalon master address (word aligned) and strobes
//   waitrequest           Avalon stall
//   writedata/byteenable  lane-steered store data and lane enables
//   readdata              Avalon read data
// Parameters: ADDR_W (address width), RD_LAT (read latency, 0 or 1).
// Optional feature macro: MIPS_LSU_UNALIGNED_EN (LWL/LWR/SWL/SWR).
module mips_lsu
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  lsu_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       old_q, old_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              st_err;
  logic [31:0]       ld_result;
  logic              store_q;

  mips_lsu_align u_align (
    .st_op    (req_op),
    .st_k     (req_addr[1:0]),
    .st_data  (req_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .st_err   (st_err),
    .ld_op    (op_q),
    .ld_k     (k_q),
    .ld_rdata (readdata),
    .ld_old   (old_q),
    .ld_result(ld_result)
  );

  assign store_q = lsu_is_store(op_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LSU_IDLE;
      op_q    <= LSU_LB;
      k_q     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid && !reset) begin
          op_d    = req_op;
          k_d     = req_addr[1:0];
          old_d   = req_wdata;
          rdata_d = '0;
          err_d   = st_err;
          if (st_err) begin
            state_d = LSU_RESP;
          end else begin
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            be_d    = st_be;
            wdata_d = lsu_is_store(req_op) ? st_wdata : '0;
            state_d = LSU_BUS;
          end
        end
      end
      LSU_BUS: begin
        if (!waitrequest) begin
          if (store_q) begin
            state_d = LSU_RESP;
          end else if (RD_LAT == 0) begin
            rdata_d = ld_result;
            state_d = LSU_RESP;
          end else begin
            state_d = LSU_RDATA;
          end
        end
      end
      LSU_RDATA: begin
        rdata_d = ld_result;
        state_d = LSU_RESP;
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  assign req_ready  = (state_q == LSU_IDLE) && !reset;
  assign resp_valid = (state_q == LSU_RESP);
  assign resp_err   = (state_q == LSU_RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign read       = (state_q == LSU_BUS) && !store_q;
  assign write      = (state_q == LSU_BUS) && store_q;
  assign address    = addr_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: scoreboard bench for mips_lsu (RD_LAT=1). The stimulus
// process pushes expected bus beats and responses into queues; a bus
// process acts as the Avalon slave and checks strobe cycles, and a monitor
// process checks each resp_valid pulse against the response queue.
module tb_mips_lsu;
  import mips_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } resp_t;

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem;
    int unsigned nwait;
  } bus_t;

  logic        clk, reset;
  logic        req_valid, req_ready;
  lsu_op_t     req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic        read, write, waitrequest;
  logic [31:0] writedata, readdata;
  logic [3:0]  byteenable;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  mips_lsu #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_load(input lsu_op_t op);
    return (op == LSU_LB) || (op == LSU_LBU) || (op == LSU_LH) ||
           (op == LSU_LHU) || (op == LSU_LW) || (op == LSU_LWL) || (op == LSU_LWR);
  endfunction

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          check({r.name, " rdata"}, resp_rdata, r.rdata);
          check({r.name, " err"}, {31'd0, resp_err}, {31'd0, r.err});
          check({r.name, " resp_cycle"}, cyc, r.cyc);
        end
      end
    end
  end

  // Avalon slave and bus-beat checker.
  initial begin
    bus_t        b;
    logic        rd_pend;
    logic [31:0] rd_val;
    logic [31:0] mask;
    rd_pend     = 1'b0;
    rd_val      = '0;
    waitrequest = 1'b0;
    readdata    = 32'h5A5A_A5A5;
    forever begin
      @(negedge clk);
      readdata = rd_pend ? rd_val : 32'h5A5A_A5A5;
      rd_pend  = 1'b0;
      if (read && write) check("read_write_overlap", 32'd1, 32'd0);
      if (read || write) begin
        if (bus_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
          waitrequest = 1'b0;
        end else begin
          b = bus_q[0];
          mask = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
          check({b.name, " strobe"}, {30'd0, read, write}, {30'd0, b.rd, !b.rd});
          check({b.name, " address"}, address, b.addr);
          check({b.name, " byteenable"}, {28'd0, byteenable}, {28'd0, b.be});
          if (!b.rd) check({b.name, " writedata"}, writedata & mask, b.wdata & mask);
          if (b.nwait > 0) begin
            waitrequest = 1'b1;
            bus_q[0].nwait = b.nwait - 1;
          end else begin
            waitrequest = 1'b0;
            if (b.rd) begin
              rd_pend = 1'b1;
              rd_val  = b.mem;
            end
            void'(bus_q.pop_front());
          end
        end
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  task automatic issue(input string name, input lsu_op_t op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mem,
                       input int unsigned nwait, input logic bus, input logic [3:0] be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int unsigned lat);
    resp_t r;
    bus_t  b;
    int unsigned t = 0;
    @(negedge clk); #2;
    while (!req_ready && t < 50) begin
      @(negedge clk); #2;
      t++;
    end
    check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    r.name = name; r.rdata = exp_rd; r.err = exp_err; r.cyc = cyc + lat;
    resp_q.push_back(r);
    if (bus) begin
      b.name = name; b.rd = is_load(op); b.addr = {addr[31:2], 2'b00};
      b.be = be; b.wdata = exp_wd; b.mem = mem; b.nwait = nwait;
      bus_q.push_back(b);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = LSU_SW; req_addr = 32'hFFFF_FFF0; req_wdata = 32'hFFFF_FFFF;
    t = 0;
    while (resp_q.size() != 0 && t < 40) begin
      @(negedge clk); #2;
      t++;
    end
    if (resp_q.size() != 0) begin
      check({name, " response_timeout"}, 32'd1, 32'd0);
      resp_q.delete();
      bus_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = LSU_LB; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    check("reset strobes_resp", {28'd0, resp_valid, resp_err, read, write}, 32'd0);
    check("reset address", address, 32'd0);
    check("reset writedata", writedata, 32'd0);
    check("reset byteenable", {28'd0, byteenable}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk); #2;
    check("post_reset req_ready", {31'd0, req_ready}, 32'd1);

    //     name          op       addr          wdata         mem           w  bus  be       exp_wd        exp_rd        err lat
    issue("sw_word",     LSU_SW,  32'h1000, 32'hDEAD_BEEF, 32'h0,        0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 2);
    issue("lb_neg",      LSU_LB,  32'h1003, 32'h0,         32'h80FF_0000, 0, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 3);
    issue("lbu",         LSU_LBU, 32'h1003, 32'h0,         32'h80FF_0000, 0, 1, 4'b1000, 32'h0,        32'h0000_0080, 0, 3);
    issue("sh_wait3",    LSU_SH,  32'h2002, 32'h0000_1234, 32'h0,        3, 1, 4'b1100, 32'h1234_0000, 32'h0,        0, 5);
    issue("lw_misalign", LSU_LW,  32'h1002, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue("lh_hi",       LSU_LH,  32'h1002, 32'h0,         32'h8001_7FFF, 0, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 3);
    issue("lhu_wait2",   LSU_LHU, 32'h1000, 32'h0,         32'h8001_7FFF, 2, 1, 4'b0011, 32'h0,        32'h0000_7FFF, 0, 5);
    issue("sb_lane1",    LSU_SB,  32'h3001, 32'h1234_56AB, 32'h0,        0, 1, 4'b0010, 32'h0000_AB00, 32'h0,        0, 2);
    issue("lw_wait1",    LSU_LW,  32'h4000, 32'h0,         32'h1234_5678, 1, 1, 4'b1111, 32'h0,        32'h1234_5678, 0, 4);
    issue("lb_pos",      LSU_LB,  32'h1001, 32'h0,         32'h0000_7F00, 0, 1, 4'b0010, 32'h0,        32'h0000_007F, 0, 3);
    issue("sh_misalign", LSU_SH,  32'h2001, 32'h0000_1234, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue("lh_misalign", LSU_LH,  32'h1001, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue("sw_misalign", LSU_SW,  32'h1003, 32'h1111_1111, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
`ifdef MIPS_LSU_UNALIGNED_EN
    issue("lwl",         LSU_LWL, 32'h1001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 4'b0011, 32'h0,        32'hCCDD_3344, 0, 3);
    issue("lwr",         LSU_LWR, 32'h1001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 4'b1110, 32'h0,        32'h11AA_BBCC, 0, 3);
    issue("swl",         LSU_SWL, 32'h1001, 32'h1122_3344, 32'h0,        0, 1, 4'b0011, 32'h0000_1122, 32'h0,        0, 2);
    issue("swr",         LSU_SWR, 32'h1001, 32'h1122_3344, 32'h0,        0, 1, 4'b1110, 32'h2233_4400, 32'h0,        0, 2);
`else
    issue("lwl_off",     LSU_LWL, 32'h1001, 32'h1122_3344, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue("lwr_off",     LSU_LWR, 32'h1001, 32'h1122_3344, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue("swl_off",     LSU_SWL, 32'h1001, 32'h1122_3344, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    issue("swr_off",     LSU_SWR, 32'h1001, 32'h1122_3344, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
`endif

    // Reset while the bus is stalled: strobe must drop, no response follows.
    begin
      bus_t b;
      @(negedge clk); #2;
      b.name = "rst_mid"; b.rd = 1'b1; b.addr = 32'h1000; b.be = 4'b1000;
      b.wdata = '0; b.mem = 32'h0; b.nwait = 100;
      bus_q.push_back(b);
      req_valid = 1'b1; req_op = LSU_LB; req_addr = 32'h1003; req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk); #2;
      check("rst_mid strobes", {30'd0, read, write}, 32'd0);
      check("rst_mid req_ready", {31'd0, req_ready}, 32'd0);
      bus_q.delete();
      reset = 1'b0;
      @(negedge clk); #2;
      check("rst_mid ready_after", {31'd0, req_ready}, 32'd1);
      repeat (5) @(negedge clk);
    end

    issue("sw_after_rst", LSU_SW, 32'h5004, 32'hCAFE_F00D, 32'h0,        0, 1, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 2);

    repeat (3) @(negedge clk);
    #2;
    check("resp_queue_empty", resp_q.size(), 32'd0);
    check("bus_queue_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit that turns one CPU memory request into one Avalon-MM master transaction, covering byte, halfword and word loads and stores. It sits between the multi-cycle `mips_cpu_bus` datapath and the external Avalon bus. It handles:
- `waitrequest` stalls;
- read-data latency;
- byte-lane steering and load sign/zero extension;
- misalignment detection.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width of `req_addr` and `address`.
- `RD_LAT`, 1: read-data latency after the accept cycle. Legal values are 0 or 1.

Ports:
- `clk`  in  1  clock, all state on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; the request is accepted when `req_valid && req_ready`.
- `req_op`  in  4  `lsu_op_t`: LB, LBU, LH, LHU, LW, SB, SH, SW, LWL, LWR, SWL, SWR.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; for LWL/LWR, the old rt value.
- `resp_valid`  out  1  single-cycle completion pulse.
- `resp_rdata`  out  32  load result (extended or merged); 0 for stores.
- `resp_err`  out  1  valid with `resp_valid`; set on misaligned access or a disabled op.
- `address`  out  ADDR_W  word-aligned bus address (`req_addr` with bits [1:0] = 0).
- `read`, `write`  out  1  Avalon strobes.
- `waitrequest`  in  1  Avalon stall.
- `writedata`  out  32  lane-steered store data.
- `byteenable`  out  4  active lanes.
- `readdata`  in  32  Avalon read data.

## Operation
- Byte lanes are little-endian: lane k = byte at `addr[1:0]==k` = bits [8k+7:8k].
- States:
  - IDLE: `req_ready`=1.
  - BUS: strobe held.
  - RDATA: only when `RD_LAT`=1.
  - RESP: `resp_valid`=1 for one cycle, then IDLE.
- IDLE on accept:
  - Misaligned access (H-ops with `addr[0]`≠0, W-ops with `addr[1:0]`≠0) → RESP with `resp_err`=1, no bus cycle.
  - Otherwise the request is latched → BUS.
- BUS:
  - `read` or `write`, `address`, `byteenable` and `writedata` are driven from latched values and held constant while `waitrequest`=1.
  - On the cycle with `waitrequest`=0:
    - store → RESP;
    - load with `RD_LAT`=0 → capture `readdata` → RESP;
    - load with `RD_LAT`=1 → RDATA.
- RDATA: capture `readdata` → RESP.
- Byte enables:
  - Byte ops: lane k only.
  - Half ops: lanes k, k+1.
  - Word: 4'b1111.
  - Store data is replicated or shifted into the enabled lanes.
- Load extraction: the selected lane(s) are shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- `read` and `write` are never high together. The strobe drops in the cycle after acceptance.
- `req_*` inputs are ignored outside IDLE.
- Reset mid-transaction: immediate return to IDLE with strobes deasserted next edge. No response is issued.

## Timing
- Reset values:
  - `req_ready`=0 while `reset`=1, then 1.
  - `resp_valid`, `resp_err`, `read`, `write`=0.
  - `address`, `writedata`, `byteenable`, `resp_rdata`=0.
- Accept at edge N → strobe high in cycle N+1.
- Store or `RD_LAT`=0 load with zero wait: `resp_valid` in cycle N+2. `RD_LAT`=1 load: cycle N+3. Each `waitrequest` cycle adds 1.
- Misaligned: `resp_valid` in cycle N+1.
- `req_ready` returns high the cycle after `resp_valid`. Back-to-back rate is 1 request per 3 cycles minimum.

## Configuration
- `MIPS_LSU_UNALIGNED_EN` defined (k = `addr[1:0]`):
  - LWL/LWR/SWL/SWR execute without alignment checks.
  - LWL: rdata = (mem<<8(3−k)) | (old & low (3−k) bytes).
  - LWR: rdata = (mem>>8k) | (old & high k bytes).
  - SWL: lanes 0..k = rt>>8(3−k).
  - SWR: lanes k..3 = rt<<8k.
- Undefined: these four ops take the misaligned path (`resp_err`=1, no bus cycle). Align logic for them is not compiled.

## Structure
- `mips_pkg`: `lsu_op_t` enum, `lsu_state_t` enum, lane-width constants. The package is shared with `mips_cpu_bus`, which maps opcodes to `lsu_op_t`.
- Sub-module `mips_lsu_align`: combinational store steering/byteenable plus load extract/extend/merge. Instantiated once; FSM and registers stay in `mips_lsu`.

## Test plan
- SW 0xDEADBEEF @0x1000, `waitrequest`=0 → `address`=0x1000, `byteenable`=4'hF, `resp_valid` at N+2, `resp_err`=0.
- LB @0x1003, readdata=0x80FF_0000, `RD_LAT`=1 → `byteenable`=4'b1000, `resp_rdata`=0xFFFF_FF80. LBU → 0x0000_0080.
- SH 0x1234 @0x2002 with `waitrequest` high 3 cycles → strobe and outputs stable for 4 cycles, `writedata`[31:16]=0x1234, `byteenable`=4'b1100, `resp_valid` at N+5.
- LW @0x1002 → `resp_err`=1 at N+1, `read` never asserted.
- `MIPS_LSU_UNALIGNED_EN`: LWL @0x1001, mem=0xAABBCCDD, old=0x11223344 → 0xCCDD3344. LWR same → 0x11AABBCC. Without the macro → `resp_err`=1.
- Reset asserted during BUS with `waitrequest`=1 → `read`=0 next cycle, no `resp_valid`, `req_ready`=1 after reset release.
